rom_pixel_streamer: RTL and testbench
=====================================

# rom_pixel_streamer

Sequencer that owns the address port of the 320x240 3-bit image ROM. On a start pulse it walks the ROM in raster order and delivers each pixel, tagged with its coordinates, on a valid/ready stream to the display or compositing logic. It absorbs the ROM's one-cycle read latency and downstream backpressure with a small credit-controlled output FIFO, so no pixel is ever lost or duplicated.

## Interface
- H_PIX, 320, pixels per line
- V_PIX, 240, lines per frame
- XW, 9, x coordinate width
- YW, 8, y coordinate width
- DW, 3, pixel data width
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to stream one frame; ignored while busy
- abort  in  1  synchronous cancel of the current frame
- busy  out  1  high from the cycle after start is accepted until done or abort
- done  out  1  one-cycle pulse after the final pixel handshake
- rom_x  out  XW  registered ROM x address
- rom_y  out  YW  registered ROM y address
- rom_dout  in  DW  ROM data; valid the cycle after the address is presented
- pix_data  out  DW  pixel value
- pix_x  out  XW  x coordinate of pix_data
- pix_y  out  YW  y coordinate of pix_data
- pix_eol  out  1  pixel is at x = H_PIX-1
- pix_last  out  1  pixel is at (H_PIX-1, V_PIX-1)
- pix_valid  out  1  stream valid
- pix_ready  in  1  stream ready

## Operation
- States: IDLE, SCAN, DRAIN.
- IDLE: rom_x = rom_y = 0. On start = 1, go to SCAN with the address counters at (0,0).
- SCAN, read issue: a read issues in a cycle when fifo_count + inflight <= 2, using registered values only. issue drives rom_x/rom_y for that cycle.
- SCAN, in-flight data: inflight is set the next cycle. In that cycle rom_dout is written into the FIFO, with coordinates carried in a side register.
- SCAN, address advance: after an issue, x increments. At x = H_PIX-1 it wraps to 0 and y increments.
- SCAN, exit: the issue of (H_PIX-1, V_PIX-1) moves the state to DRAIN. The address is then held.
- DRAIN: no issues. When the final pixel (pix_last) completes a handshake, assert done for one cycle and go to IDLE.
- FIFO: depth 3, first-word fall-through. pix_valid = fifo non-empty. Pop on pix_valid & pix_ready.
- Credit bound: the credit rule caps occupancy at 3. Overflow is impossible; a write into a full FIFO is an assertion failure.
- Ordering: strict raster order. Every (x,y) is emitted exactly once per frame.
- start while busy: ignored. It does not queue.
- abort (any state): next cycle go to IDLE. FIFO and inflight are flushed, counters reset to 0, pix_valid = 0. No done pulse. abort has priority over start and over the FIFO write in the same cycle.
- Simultaneous push and pop: count is unchanged.

## Timing
- Reset values: busy = done = pix_valid = pix_eol = pix_last = 0. rom_x = rom_y = pix_x = pix_y = 0. pix_data = 0. State is IDLE, fifo_count = 0, inflight = 0.
- Start latency: start sampled at edge 0. Cycle 1 presents (0,0). Cycle 2 has rom_dout valid. Cycle 3 has pix_valid = 1 with pix_x = 0, pix_y = 0.
- Throughput: 1 pixel/clk in steady state with pix_ready held high.
- Full-frame duration with pix_ready held high: pixel k valid in cycle 3+k, pix_last in cycle 76802, done in cycle 76803. busy is high in cycles 1..76802 and low in the done cycle.
- Stream hold rule: while pix_valid = 1 and pix_ready = 0, pix_data, pix_x, pix_y, pix_eol and pix_last hold stable.
- Next frame: a new start is accepted in the done cycle or later.

## Test plan
- Raster check, pix_ready = 1: ROM model returns (x+y)%8 with 1-cycle latency; start at cycle 0. Expect 76800 pixels, each pix_data = (pix_x+pix_y)%8, first at cycle 3, done at cycle 76803, 240 pix_eol pulses, one pix_last.
- Backpressure: pix_ready random at 30% high. Expect an identical pixel sequence, stable outputs while stalled, fifo_count never > 3, no missing or duplicate coordinates.
- Small frame (H_PIX=4, V_PIX=3): expect x wrap 3->0 with y increment, pix_eol at x = 3, pix_last at (3,2), done after the 12th handshake.
- start pulsed at cycle 500 mid-frame: expect it ignored, frame unchanged, single done.
- abort at pixel (100,50) with data in the FIFO: expect pix_valid = 0 next cycle, busy = 0, no done. A following start restarts at (0,0).
- rst_n low mid-frame, asynchronous: all outputs immediately at reset values; after release and start, the first pixel is (0,0) at cycle 3.

Source files
------------

// File: rtl/rom_pixel_streamer.sv
// ----------------------------------------------------------------------------
// rom_pixel_streamer : raster-order ROM walker with a credit-bounded FWFT output FIFO
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rom_pixel_streamer #(
  parameter int H_PIX = 320,
  parameter int V_PIX = 240,
  parameter int XW    = 9,
  parameter int YW    = 8,
  parameter int DW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [XW-1:0] rom_x,
  output logic [YW-1:0] rom_y,
  input  logic [DW-1:0] rom_dout,
  output logic [DW-1:0] pix_data,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic          pix_eol,
  output logic          pix_last,
  output logic          pix_valid,
  input  logic          pix_ready
);

  localparam int c_EW    = DW + XW + YW;
  localparam int c_DEPTH = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_done;
  logic           w_done_nxt;

  logic [XW-1:0]  r_x;
  logic [YW-1:0]  r_y;
  logic           r_inflight;
  logic [XW-1:0]  r_ifl_x;
  logic [YW-1:0]  r_ifl_y;

  logic [c_EW-1:0] r_mem [c_DEPTH];
  logic [1:0]      r_wp;
  logic [1:0]      r_rp;
  logic [1:0]      r_count;

  logic            w_issue;
  logic            w_xend;
  logic            w_frame_end;
  logic            w_push;
  logic            w_pop;
  logic [c_EW-1:0] w_head;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Credit: outstanding read plus stored words never exceeds the FIFO depth.
  assign w_issue     = (r_state == S_SCAN) &&
                       (({1'b0, r_count} + {2'b00, r_inflight}) <= 3'd2);
  assign w_xend      = (r_x == XW'(H_PIX - 1));
  assign w_frame_end = w_xend && (r_y == YW'(V_PIX - 1));
  assign w_push      = r_inflight && !abort;
  assign w_pop       = pix_valid && pix_ready;

  assign w_head    = r_mem[r_rp];
  assign pix_data  = w_head[c_EW-1 -: DW];
  assign pix_x     = w_head[XW+YW-1 -: XW];
  assign pix_y     = w_head[YW-1:0];
  assign pix_valid = (r_count != 2'd0);
  assign pix_eol   = pix_valid && (pix_x == XW'(H_PIX - 1));
  assign pix_last  = pix_eol && (pix_y == YW'(V_PIX - 1));

  assign busy  = (r_state != S_IDLE);
  assign done  = r_done;
  assign rom_x = r_x;
  assign rom_y = r_y;

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start) w_state_nxt = S_SCAN;
        S_SCAN:  if (w_issue && w_frame_end) w_state_nxt = S_DRAIN;
        S_DRAIN: begin
          if (w_pop && pix_last) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Address counters sit at (0,0) whenever idle so a new frame starts there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (abort || (w_state_nxt == S_IDLE)) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_issue && !w_frame_end) begin
      if (w_xend) begin
        r_x <= '0;
        r_y <= r_y + YW'(1);
      end else begin
        r_x <= r_x + XW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
      r_ifl_x    <= '0;
      r_ifl_y    <= '0;
    end else begin
      r_inflight <= w_issue && !abort;
      if (w_issue) begin
        r_ifl_x <= r_x;
        r_ifl_y <= r_y;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_DEPTH; i++) r_mem[i] <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else if (abort) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= {rom_dout, r_ifl_x, r_ifl_y};
        r_wp        <= ptr_inc(r_wp);
      end
      if (w_pop) r_rp <= ptr_inc(r_rp);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
                                   !(w_push && (r_count == 2'(c_DEPTH))));

endmodule

`default_nettype wire

// File: tb/tb_rom_pixel_streamer.sv
// ----------------------------------------------------------------------------
// tb_rom_pixel_streamer : randomized frame streaming against a raster reference
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_rom_pixel_streamer;

  localparam int H = 12;
  localparam int V = 5;
  localparam int N = H * V;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       busy;
  logic       done;
  logic [8:0] rom_x;
  logic [7:0] rom_y;
  logic [2:0] rom_dout = 3'd0;
  logic [2:0] pix_data;
  logic [8:0] pix_x;
  logic [7:0] pix_y;
  logic       pix_eol;
  logic       pix_last;
  logic       pix_valid;
  logic       pix_ready;

  int n_checks = 0;
  int n_errors = 0;

  rom_pixel_streamer #(
    .H_PIX(H), .V_PIX(V), .XW(9), .YW(8), .DW(3)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .rom_x(rom_x), .rom_y(rom_y),
    .rom_dout(rom_dout), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
    .pix_eol(pix_eol), .pix_last(pix_last), .pix_valid(pix_valid),
    .pix_ready(pix_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: one-cycle read latency, content (x+y) mod 8.
  always @(posedge clk) rom_dout <= 3'((32'(rom_x) + 32'(rom_y)) % 8);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_valid"}, pix_valid, 0);
    chk({tag, "_eol"}, pix_eol, 0);
    chk({tag, "_last"}, pix_last, 0);
    chk({tag, "_romx"}, rom_x, 0);
    chk({tag, "_romy"}, rom_y, 0);
    chk({tag, "_pixx"}, pix_x, 0);
    chk({tag, "_pixy"}, pix_y, 0);
    chk({tag, "_data"}, pix_data, 0);
  endtask

  // One frame: pct = percent of cycles with pix_ready high; glitch = cycle of a
  // stray start; abort_k / rst_k = pixel index after which abort / reset hits.
  task automatic run_frame(input int pct, input int glitch, input int abort_k, input int rst_k);
    int  k, eols, lasts, ex, ey;
    bit  stall, fin;
    logic [2:0] pd;
    logic [8:0] px;
    logic [7:0] py;
    logic pe, pl;
    k = 0; eols = 0; lasts = 0; stall = 0; fin = 0;
    pd = '0; px = '0; py = '0; pe = 0; pl = 0;
    @(posedge clk); #1;
    start     = 1'b1;
    pix_ready = ($urandom_range(0, 99) < pct);
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= N * 20 + 50 && !fin; n++) begin
      @(negedge clk);
      if (n == 1) begin
        chk("busy_c1", busy, 1);
        chk("romx_c1", rom_x, 0);
        chk("romy_c1", rom_y, 0);
        chk("valid_c1", pix_valid, 0);
      end
      if (n == 2) chk("valid_c2", pix_valid, 0);
      if (n == 3) begin
        chk("valid_c3", pix_valid, 1);
        chk("first_x", pix_x, 0);
        chk("first_y", pix_y, 0);
      end
      if (stall) begin
        chk("hold_valid", pix_valid, 1);
        chk("hold_data", pix_data, pd);
        chk("hold_x", pix_x, px);
        chk("hold_y", pix_y, py);
        chk("hold_eol", pix_eol, pe);
        chk("hold_last", pix_last, pl);
      end
      if (done) begin
        chk("pixels_at_done", k, N);
        chk("busy_at_done", busy, 0);
        chk("valid_at_done", pix_valid, 0);
        if (pct == 100) chk("done_cycle", n, N + 3);
        fin = 1;
      end else if (k < N) begin
        chk("busy_run", busy, 1);
      end
      if (pix_valid && pix_ready) begin
        ex = k % H;
        ey = k / H;
        chk("pix_in_frame", (k < N), 1);
        chk("pix_x", pix_x, ex);
        chk("pix_y", pix_y, ey);
        chk("pix_data", pix_data, (ex + ey) % 8);
        chk("pix_eol", pix_eol, (ex == H - 1));
        chk("pix_last", pix_last, (k == N - 1));
        eols  += int'(pix_eol);
        lasts += int'(pix_last);
        k++;
      end
      stall = pix_valid && !pix_ready;
      pd = pix_data; px = pix_x; py = pix_y; pe = pix_eol; pl = pix_last;
      if (!fin) begin
        @(posedge clk); #1;
        if (abort_k >= 0 && k >= abort_k && pix_valid) begin
          abort = 1'b1;
          @(posedge clk); #1;
          abort = 1'b0;
          @(negedge clk);
          chk("abort_valid", pix_valid, 0);
          chk("abort_busy", busy, 0);
          chk("abort_romx", rom_x, 0);
          chk("abort_romy", rom_y, 0);
          repeat (8) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
            chk("abort_idle", pix_valid, 0);
          end
          return;
        end
        if (rst_k >= 0 && k >= rst_k) begin
          #2 rst_n = 1'b0;
          #1 check_reset("async_rst");
          @(posedge clk); #1;
          rst_n = 1'b1;
          return;
        end
        pix_ready = ($urandom_range(0, 99) < pct);
        start     = (n == glitch);
      end
    end
    chk("frame_done_seen", fin, 1);
    chk("eol_count", eols, V);
    chk("last_count", lasts, 1);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", busy, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    pix_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset("reset");
    rst_n = 1'b1;

    run_frame(100, -1, -1, -1);
    run_frame(30, int'($urandom_range(5, 40)), -1, -1);
    run_frame(50, -1, int'($urandom_range(N / 3, 2 * N / 3)), -1);
    run_frame(100, -1, -1, -1);
    run_frame(60, -1, -1, int'($urandom_range(10, N - 10)));
    run_frame(100, -1, -1, -1);
    run_frame(45, int'($urandom_range(5, 60)), -1, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
